intr_gen: RTL and testbench

Machine-level interrupt source block feeding the CSR register file's `t_intr`/`e_intr` inputs. It contains:
- a memory-mapped 64-bit `mtime` counter with a prescaler, and a 64-bit `mtimecmp` compare register;
- a synchronizer and rising-edge detector for one asynchronous external interrupt line.

Both sources are turned into single-cycle, registered interrupt pulses. It sits on the data-memory bus, upstream of the CSR file.

---
 rtl/intr_pkg.sv | 26 ++
 rtl/intr_gen_sync_edge.sv | 32 +++
 rtl/intr_gen.sv | 163 ++++++++++++++++
 tb/tb_intr_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// intr_pkg: shared constants for the machine-level interrupt source block.
// Contents: register byte offsets, CTRL/STATUS bit positions, the PRESC field
// range and the MTIMECMP reset value.
package intr_pkg;

    // Register byte offsets within the 32-byte window
    localparam logic [4:0] REG_MTIME_LO    = 5'h00;
    localparam logic [4:0] REG_MTIME_HI    = 5'h04;
    localparam logic [4:0] REG_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] REG_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] REG_CTRL        = 5'h10;
    localparam logic [4:0] REG_STATUS      = 5'h14;

    // CTRL fields
    localparam int CTRL_TEN_BIT    = 0;
    localparam int CTRL_EEN_BIT    = 1;
    localparam int CTRL_PRESC_LSB  = 8;
    localparam int CTRL_PRESC_MSB  = 15;

    // STATUS fields
    localparam int STATUS_TPEND_BIT = 0;
    localparam int STATUS_EPEND_BIT = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/intr_gen_sync_edge.sv
// sync_edge: two-flop synchronizer followed by an edge flop.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset (all flops to 0)
//   async_i - asynchronous level input
//   rise_o  - high for one cycle when the synchronized level goes 0 -> 1
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= async_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise_o = r_sync2 & ~r_prev;

endmodule

// File: rtl/intr_gen.sv
// intr_gen: machine timer (mtime/mtimecmp with prescaler) and external
// interrupt edge detector, producing single-cycle registered pulses for the
// CSR file.
// Ports:
//   clk_i, rst_ni     - clock, asynchronous active-low reset
//   addr_i            - byte address in the register window ([1:0] ignored)
//   we_i / re_i       - write / read strobes; a strobe is a complete access in
//                       the cycle it is high (no wait states, no ready signal)
//   wdata_i           - write data (full-word writes)
//   rdata_o           - combinational read data, 0 unless re_i and mapped
//   ext_irq_i         - asynchronous external interrupt level
//   t_intr / e_intr   - one-cycle timer / external interrupt pulses
module intr_gen
    import intr_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    input  logic          ext_irq_i,
    output logic          t_intr,
    output logic          e_intr
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_ten;
    logic        r_een;
    logic [7:0]  r_presc;
    logic [7:0]  r_presc_cnt;
    logic [31:0] r_mtime_hi_shadow;
    logic        r_epend;
    logic        r_tpend_q;
    logic        r_t_intr;
    logic        r_e_intr;

    logic [AW-1:0] w_off;
    logic          w_wr_mlo, w_wr_mhi, w_wr_clo, w_wr_chi, w_wr_ctrl, w_wr_stat;
    logic          w_rd_mlo;
    logic          w_tick;
    logic          w_tpend;
    logic          w_ext_rise;
    logic          w_eset;
    logic          w_unused_ok;

    assign w_unused_ok = &{1'b0, addr_i[1:0]};

    // Word-aligned offset; the low address bits never select anything
    assign w_off     = {addr_i[AW-1:2], 2'b00};
    assign w_wr_mlo  = we_i && (w_off == AW'(REG_MTIME_LO));
    assign w_wr_mhi  = we_i && (w_off == AW'(REG_MTIME_HI));
    assign w_wr_clo  = we_i && (w_off == AW'(REG_MTIMECMP_LO));
    assign w_wr_chi  = we_i && (w_off == AW'(REG_MTIMECMP_HI));
    assign w_wr_ctrl = we_i && (w_off == AW'(REG_CTRL));
    assign w_wr_stat = we_i && (w_off == AW'(REG_STATUS));
    assign w_rd_mlo  = re_i && (w_off == AW'(REG_MTIME_LO));

    assign w_tick  = r_ten && (r_presc_cnt == r_presc);
    assign w_tpend = r_ten && (r_mtime >= r_mtimecmp);

    sync_edge u_ext_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (ext_irq_i),
        .rise_o  (w_ext_rise)
    );

    // Edges arriving while EEN=0 are dropped, not remembered
    assign w_eset = w_ext_rise && r_een;

    // Prescaler and CTRL
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc_cnt <= 8'd0;
            r_ten       <= 1'b0;
            r_een       <= 1'b0;
            r_presc     <= 8'd0;
        end else begin
            if (w_wr_ctrl || !r_ten || w_tick)
                r_presc_cnt <= 8'd0;
            else
                r_presc_cnt <= r_presc_cnt + 8'd1;
            if (w_wr_ctrl) begin
                r_ten   <= wdata_i[CTRL_TEN_BIT];
                r_een   <= wdata_i[CTRL_EEN_BIT];
                r_presc <= wdata_i[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
            end
        end
    end

    // mtime / mtimecmp / HI read shadow. A write to either mtime half
    // suppresses that cycle's increment, so the written value never carries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime           <= 64'd0;
            r_mtimecmp        <= MTIMECMP_RST;
            r_mtime_hi_shadow <= 32'd0;
        end else begin
            if (w_wr_mlo)
                r_mtime[31:0] <= wdata_i[31:0];
            else if (w_wr_mhi)
                r_mtime[63:32] <= wdata_i[31:0];
            else if (w_tick)
                r_mtime <= r_mtime + 64'd1;
            if (w_wr_clo)
                r_mtimecmp[31:0] <= wdata_i[31:0];
            if (w_wr_chi)
                r_mtimecmp[63:32] <= wdata_i[31:0];
            if (w_rd_mlo)
                r_mtime_hi_shadow <= r_mtime[63:32];
        end
    end

    // Pending flag and pulse registers. Set of EPEND beats a coincident W1C.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_epend   <= 1'b0;
            r_tpend_q <= 1'b0;
            r_t_intr  <= 1'b0;
            r_e_intr  <= 1'b0;
        end else begin
            if (w_eset)
                r_epend <= 1'b1;
            else if (w_wr_stat && wdata_i[STATUS_EPEND_BIT])
                r_epend <= 1'b0;
            r_tpend_q <= w_tpend;
            r_t_intr  <= w_tpend && !r_tpend_q;
            r_e_intr  <= w_eset;
        end
    end

    assign t_intr = r_t_intr;
    assign e_intr = r_e_intr;

    always_comb begin
        rdata_o = '0;
        if (re_i) begin
            case (w_off)
                AW'(REG_MTIME_LO):    rdata_o = r_mtime[31:0];
                AW'(REG_MTIME_HI):    rdata_o = r_mtime_hi_shadow;
                AW'(REG_MTIMECMP_LO): rdata_o = r_mtimecmp[31:0];
                AW'(REG_MTIMECMP_HI): rdata_o = r_mtimecmp[63:32];
                AW'(REG_CTRL): begin
                    rdata_o[CTRL_TEN_BIT] = r_ten;
                    rdata_o[CTRL_EEN_BIT] = r_een;
                    rdata_o[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = r_presc;
                end
                AW'(REG_STATUS): begin
                    rdata_o[STATUS_TPEND_BIT] = w_tpend;
                    rdata_o[STATUS_EPEND_BIT] = r_epend;
                end
                default: rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_gen.sv
// Self-checking bench for intr_gen against a behavioural register-level model.
module tb_intr_gen;
    import intr_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic [4:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ext_irq;
    logic        t_intr;
    logic        e_intr;

    intr_gen #(.DW(32), .AW(5)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .addr_i    (addr),
        .we_i      (we),
        .re_i      (re),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .ext_irq_i (ext_irq),
        .t_intr    (t_intr),
        .e_intr    (e_intr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] m_mtime, m_cmp;
    logic        m_ten, m_een, m_epend, m_tp_prev;
    logic [7:0]  m_presc, m_cnt;
    logic [31:0] m_shadow;
    logic [3:0]  m_ext_h;          // [0] = ext at latest edge, [k] = k edges earlier
    logic [1:0]  exp_q[$];         // expected {t_intr, e_intr} after each edge

    int n_checks = 0;
    int n_err    = 0;
    int t_seen   = 0;
    int e_seen   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_ten = 0; m_een = 0; m_presc = 0; m_cnt = 0;
        m_shadow = 0; m_epend = 0; m_tp_prev = 0; m_ext_h = 0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] v;
        v = 32'd0;
        case ({a[4:2], 2'b00})
            5'h00: v = m_mtime[31:0];
            5'h04: v = m_shadow;
            5'h08: v = m_cmp[31:0];
            5'h0C: v = m_cmp[63:32];
            5'h10: v = {16'd0, m_presc, 6'd0, m_een, m_ten};
            5'h14: v = {30'd0, m_epend, (m_ten && m_mtime >= m_cmp)};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Advance the model across one rising edge using the current bus inputs.
    task automatic model_step();
        logic       tp, det, t_exp, e_exp, tick, wr_m;
        logic [4:0] off;
        off  = {addr[4:2], 2'b00};
        tp   = m_ten && (m_mtime >= m_cmp);
        t_exp = tp && !m_tp_prev;
        m_tp_prev = tp;
        m_ext_h = {m_ext_h[2:0], ext_irq};
        det   = m_ext_h[2] && !m_ext_h[3];   // rising edge two edges ago, now visible
        e_exp = det && m_een;
        tick  = m_ten && (m_cnt == m_presc);
        wr_m  = we && (off == 5'h00 || off == 5'h04);
        if (re && off == 5'h00) m_shadow = m_mtime[63:32];
        if (wr_m) begin
            if (off == 5'h00) m_mtime[31:0] = wdata; else m_mtime[63:32] = wdata;
        end else if (tick) m_mtime = m_mtime + 64'd1;
        if (we && off == 5'h10) m_cnt = 0;
        else if (!m_ten || tick) m_cnt = 0;
        else m_cnt = m_cnt + 8'd1;
        if (we && off == 5'h08) m_cmp[31:0] = wdata;
        if (we && off == 5'h0C) m_cmp[63:32] = wdata;
        if (we && off == 5'h10) begin
            m_ten = wdata[0]; m_een = wdata[1]; m_presc = wdata[15:8];
        end
        if (e_exp) m_epend = 1'b1;
        else if (we && off == 5'h14 && wdata[1]) m_epend = 1'b0;
        exp_q.push_back({t_exp, e_exp});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [1:0] p;
        @(posedge clk);
        model_step();
        @(negedge clk);
        p = exp_q.pop_front();
        check("t_intr", {63'd0, t_intr}, {63'd0, p[1]});
        check("e_intr", {63'd0, e_intr}, {63'd0, p[0]});
        if (t_intr) t_seen++;
        if (e_intr) e_seen++;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        #1;
        check("rdata", {32'd0, rdata}, {32'd0, m_read(a)});
        d = rdata;
        tick();
        re = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] d;
    logic [4:0]  offs [8];
    logic        hit;

    initial begin
        offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
        rst_ni = 1'b0; addr = 0; we = 0; re = 0; wdata = 0; ext_irq = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // Reset values
        bus_read(REG_MTIME_LO, d);    check("rst_mlo", {32'd0, d}, 64'h0);
        bus_read(REG_MTIME_HI, d);    check("rst_mhi", {32'd0, d}, 64'h0);
        bus_read(REG_MTIMECMP_LO, d); check("rst_clo", {32'd0, d}, 64'hFFFF_FFFF);
        bus_read(REG_MTIMECMP_HI, d); check("rst_chi", {32'd0, d}, 64'hFFFF_FFFF);
        bus_read(REG_CTRL, d);        check("rst_ctrl", {32'd0, d}, 64'h0);
        bus_read(REG_STATUS, d);      check("rst_stat", {32'd0, d}, 64'h0);
        addr = REG_MTIMECMP_LO; #1;
        check("rdata_idle", {32'd0, rdata}, 64'h0);
        t_seen = 0; e_seen = 0;
        repeat (100) tick();
        check("rst_no_t", t_seen, 0);
        check("rst_no_e", e_seen, 0);

        // Timer, PRESC=0, mtimecmp=10
        bus_write(REG_MTIMECMP_LO, 32'd10);
        bus_write(REG_MTIMECMP_HI, 32'd0);
        t_seen = 0;
        bus_write(REG_CTRL, 32'h1);
        repeat (20) tick();
        check("tmr_once", t_seen, 1);
        bus_read(REG_STATUS, d);      check("tpend_hi", {63'd0, d[0]}, 64'd1);
        t_seen = 0;
        bus_write(REG_MTIMECMP_HI, 32'd1);
        repeat (10) tick();
        check("tmr_nopulse", t_seen, 0);
        bus_read(REG_STATUS, d);      check("tpend_lo", {63'd0, d[0]}, 64'd0);

        // Prescaler
        bus_write(REG_CTRL, 32'h0);
        bus_write(REG_MTIME_LO, 32'd0);
        bus_write(REG_MTIME_HI, 32'd0);
        bus_write(REG_CTRL, 32'h301);
        repeat (40) tick();
        bus_read(REG_MTIME_LO, d);    check("presc_10", {32'd0, d}, 64'd10);
        bus_write(REG_CTRL, 32'h300);
        repeat (20) tick();
        bus_read(REG_MTIME_LO, d);    check("frozen_10", {32'd0, d}, 64'd10);

        // Wrap and HI shadow
        bus_write(REG_CTRL, 32'h0);
        bus_write(REG_MTIME_LO, 32'hFFFF_FFFE);
        bus_write(REG_MTIME_HI, 32'hFFFF_FFFF);
        bus_write(REG_CTRL, 32'h1);
        tick();
        bus_read(REG_MTIME_LO, d);    check("wrap_lo", {32'd0, d}, 64'hFFFF_FFFF);
        bus_read(REG_MTIME_HI, d);    check("shadow_hi", {32'd0, d}, 64'hFFFF_FFFF);
        bus_read(REG_MTIME_LO, d);    check("wrap_lo1", {32'd0, d}, 64'd1);
        bus_read(REG_MTIME_HI, d);    check("wrap_hi0", {32'd0, d}, 64'd0);

        // External, EEN=1
        bus_write(REG_CTRL, 32'h2);
        bus_write(REG_STATUS, 32'h2);
        e_seen = 0;
        ext_irq = 1'b1;
        repeat (10) tick();
        ext_irq = 1'b0;
        repeat (4) tick();
        check("ext_once", e_seen, 1);
        bus_read(REG_STATUS, d);      check("epend_set", {63'd0, d[1]}, 64'd1);
        ext_irq = 1'b1;
        tick(); tick();
        bus_write(REG_STATUS, 32'h2);   // W1C lands on the edge that sets EPEND
        bus_read(REG_STATUS, d);      check("set_wins", {63'd0, d[1]}, 64'd1);
        ext_irq = 1'b0;
        repeat (4) tick();
        bus_write(REG_STATUS, 32'h2);
        bus_read(REG_STATUS, d);      check("w1c", {63'd0, d[1]}, 64'd0);

        // External, EEN=0
        bus_write(REG_CTRL, 32'h0);
        e_seen = 0;
        ext_irq = 1'b1;
        repeat (10) tick();
        ext_irq = 1'b0;
        repeat (4) tick();
        check("een0_nopulse", e_seen, 0);
        bus_read(REG_STATUS, d);      check("een0_epend", {63'd0, d[1]}, 64'd0);

        // Randomized mix
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [4:0] a;
            if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
            op = $urandom_range(0, 9);
            a  = offs[$urandom_range(0, 7)];
            if (op < 2) begin
                case (a)
                    5'h00:   bus_write(a, $urandom_range(0, 40));
                    5'h08:   bus_write(a, $urandom_range(0, 60));
                    5'h10:   bus_write(a, {16'd0, 8'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3))});
                    default: bus_write(a, ($urandom_range(0, 3) == 0) ? $urandom : 32'd0);
                endcase
            end else if (op < 5) begin
                bus_read(a, d);
            end else begin
                tick();
            end
        end
        ext_irq = 1'b0;

        // Reset during a t_intr pulse
        bus_write(REG_CTRL, 32'h0);
        bus_write(REG_MTIME_LO, 32'd0);
        bus_write(REG_MTIME_HI, 32'd0);
        bus_write(REG_MTIMECMP_HI, 32'd0);
        bus_write(REG_MTIMECMP_LO, 32'd5);
        bus_write(REG_CTRL, 32'h1);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            tick();
            hit = t_intr;
        end
        check("pulse_seen", {63'd0, hit}, 64'd1);
        rst_ni = 1'b0;
        #1;
        check("rst_async_t", {63'd0, t_intr}, 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        bus_read(REG_MTIME_LO, d);    check("post_mlo", {32'd0, d}, 64'd0);
        bus_read(REG_MTIME_HI, d);    check("post_mhi", {32'd0, d}, 64'd0);
        bus_read(REG_MTIMECMP_LO, d); check("post_clo", {32'd0, d}, 64'hFFFF_FFFF);
        bus_read(REG_MTIMECMP_HI, d); check("post_chi", {32'd0, d}, 64'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
